cond_unit: RTL and testbench
============================

# cond_unit

Condition-code register and branch-resolution unit in the EX stage; the consumer end of the adder's flag interface. Latches the adder's zero/pos/neg/overflow flags on a flag write. Tracks flag writers issued but not yet written back and stalls branches until their flags are final. Resolves accepted branches against a 4-bit condition and returns a registered taken/redirect result one cycle later.

## Interface
Parameters:
- ADDR_W, 32, width of branch target and fall-through PC
- MAX_PEND, 3, maximum outstanding flag writers (counter saturates here)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- flag_issue_i  in  1  a flag-setting instruction entered the pipe this cycle
- flag_we_i  in  1  adder flags valid this cycle, write register
- zero_flag_i / pos_flag_i / neg_flag_i / overflow_flag_i  in  1 each  adder flags
- br_valid_i  in  1  branch request
- br_ready_o  out  1  branch accepted when br_valid_i & br_ready_o
- cond_i  in  4  condition code
- target_i  in  ADDR_W  taken target
- pc_next_i  in  ADDR_W  fall-through PC
- flush_i  in  1  cancel the branch result due next cycle
- res_valid_o  out  1  one-cycle result strobe
- taken_o  out  1  branch taken
- redirect_pc_o  out  ADDR_W  target_i if taken else pc_next_i
- illegal_o  out  1  reserved cond with res_valid_o
- flags_o  out  4  {overflow, neg, pos, zero} register
- pend_full_o  out  1  pending count == MAX_PEND

## Operation
- Flag register: on flag_we_i, loads {of, nf, pf, zf} from inputs; otherwise holds.
- Pending counter pend (2 bits): +1 on flag_issue_i, -1 on flag_we_i, unchanged when both. Saturates at MAX_PEND (issue at full ignored, pend_full_o high). Floors at 0 (flag_we_i at 0 latches flags, pend stays 0).
- br_ready_o = (pend == 0) | (pend == 1 & flag_we_i). A flag_issue_i in the same cycle as a branch is younger than the branch and does not block it.
- Effective flags for evaluation: incoming flags when flag_we_i, else register (bypass).
- Conditions:
  - 0 AL: 1
  - 1 NV: 0
  - 2 EQ: z
  - 3 NE: ~z
  - 4 GE: p
  - 5 LT: n
  - 6 GT: p & ~z
  - 7 LE: n | z
  - 8 OV: o
  - 9 NO: ~o
  - 10–15 reserved: not taken, illegal_o = 1
- Accepted branch: evaluation registered into result stage.
- flush_i in the cycle after acceptance forces res_valid_o = 0 and illegal_o = 0. flush_i never affects pend or flags.
- br_valid_i without ready: nothing latched; requester holds inputs stable.

## Timing
- Reset (async assert, sync release): flags_o = 0, pend = 0, res_valid_o = 0, taken_o = 0, redirect_pc_o = 0, illegal_o = 0, pend_full_o = 0.
- br_ready_o is combinational from pend and flag_we_i. During reset it is 1 with pend = 0.
- Latency: accept in cycle N → res_valid_o, taken_o, redirect_pc_o, illegal_o valid in N+1, res_valid_o high exactly one cycle.
- taken_o and redirect_pc_o hold their last value when res_valid_o = 0.
- Back-to-back branches: one per cycle at full throughput when pend = 0.
- Reset mid-stall: pend cleared, next branch is ready immediately.

## Structure
- Shared package: condition-code constants COND_AL … COND_NO, flag bit indices (ZF = 0, PF = 1, NF = 2, OF = 3), MAX_PEND default.
- One sub-module: cond_eval, purely combinational, 4-bit flags + cond → {taken, illegal}; reused by later branch-prediction checks.
- Top: flag register, pending counter, ready logic, result register.

## Test plan
- Reset, then br_valid_i with cond = 0 (AL), target = 0x100 → br_ready_o = 1; next cycle res_valid_o = 1, taken_o = 1, redirect_pc_o = 0x100.
- flag_we_i with zf = 1, pf = 1; then branches EQ, NE, GT, GE with target 0x40 and pc_next 0x8 → taken 1, 0, 0, 1; redirect 0x40, 0x8, 0x8, 0x40.
- flag_issue_i, then branch EQ held → br_ready_o = 0 for 2 cycles. flag_we_i with zf = 1 in cycle 3 → accepted that cycle using bypassed flags, taken_o = 1 in cycle 4, pend = 0.
- Four flag_issue_i without writes → pend = 3, pend_full_o = 1. One flag_we_i → pend = 2, pend_full_o = 0. Simultaneous issue + we → pend stays 2.
- Accept LT branch, then flush_i next cycle → res_valid_o stays 0. cond = 12 unflushed → taken_o = 0, illegal_o = 1, redirect_pc_o = pc_next_i.
- Assert rst_n_i low mid-stall (pend = 2) → all outputs reset values asynchronously, br_ready_o = 1 after release.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// Shared constants for the EX-stage condition-code and branch-resolution unit.
// Condition codes, flag bit positions and the default writer-tracking depth.
package cond_unit_pkg;

    localparam int ZF = 0;
    localparam int PF = 1;
    localparam int NF = 2;
    localparam int OF = 3;

    localparam int MAX_PEND_DEF = 3;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_NV = 4'd1;
    localparam logic [3:0] COND_EQ = 4'd2;
    localparam logic [3:0] COND_NE = 4'd3;
    localparam logic [3:0] COND_GE = 4'd4;
    localparam logic [3:0] COND_LT = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_OV = 4'd8;
    localparam logic [3:0] COND_NO = 4'd9;

endpackage

// File: rtl/cond_unit_cond_eval.sv
// Combinational condition evaluator: flags + condition code -> taken/illegal.
// Codes above NO are reserved and resolve not-taken with illegal set.
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       taken_o,
    output logic       illegal_o
);

    logic z;
    logic p;
    logic n;
    logic o;

    assign z = flags_i[ZF];
    assign p = flags_i[PF];
    assign n = flags_i[NF];
    assign o = flags_i[OF];

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        unique case (cond_i)
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b0;
            COND_EQ: taken_o = z;
            COND_NE: taken_o = ~z;
            COND_GE: taken_o = p;
            COND_LT: taken_o = n;
            COND_GT: taken_o = p & ~z;
            COND_LE: taken_o = n | z;
            COND_OV: taken_o = o;
            COND_NO: taken_o = ~o;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition-code register, outstanding flag-writer tracking and branch
// resolution with a one-cycle registered result.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_PEND = MAX_PEND_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flag_issue_i,
    input  logic              flag_we_i,
    input  logic              zero_flag_i,
    input  logic              pos_flag_i,
    input  logic              neg_flag_i,
    input  logic              overflow_flag_i,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [3:0]        cond_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              flush_i,
    output logic              res_valid_o,
    output logic              taken_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              illegal_o,
    output logic [3:0]        flags_o,
    output logic              pend_full_o
);

    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    logic [3:0]        flags_q;
    logic [3:0]        flags_in;
    logic [3:0]        flags_eff;
    logic [1:0]        pend_q;
    logic              accept;
    logic              ev_taken;
    logic              ev_illegal;
    logic              res_q;
    logic              taken_q;
    logic              illegal_q;
    logic [ADDR_W-1:0] pc_q;

    assign flags_in  = {overflow_flag_i, neg_flag_i, pos_flag_i, zero_flag_i};
    assign flags_eff = flag_we_i ? flags_in : flags_q;

    // The last outstanding writer completing this cycle frees the branch.
    assign br_ready_o = (pend_q == 2'd0) | ((pend_q == 2'd1) & flag_we_i);
    assign accept     = br_valid_i & br_ready_o;

    cond_eval u_eval (
        .flags_i   (flags_eff),
        .cond_i    (cond_i),
        .taken_o   (ev_taken),
        .illegal_o (ev_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_q <= '0;
        end else if (flag_we_i) begin
            flags_q <= flags_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            unique case ({flag_issue_i, flag_we_i})
                2'b10: if (pend_q != PEND_MAX) pend_q <= pend_q + 2'd1;
                2'b01: if (pend_q != 2'd0) pend_q <= pend_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_q     <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            res_q <= accept;
            if (accept) begin
                taken_q   <= ev_taken;
                illegal_q <= ev_illegal;
                pc_q      <= ev_taken ? target_i : pc_next_i;
            end
        end
    end

    // A flush in the result cycle cancels the strobe but not the held data.
    assign res_valid_o   = res_q & ~flush_i;
    assign illegal_o     = illegal_q & res_q & ~flush_i;
    assign taken_o       = taken_q;
    assign redirect_pc_o = pc_q;
    assign flags_o       = flags_q;
    assign pend_full_o   = (pend_q == PEND_MAX);

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: reference model of flags/pending count
// plus a scoreboard queue of expected branch results.
module tb_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        flag_issue;
    logic        flag_we;
    logic        zf;
    logic        pf;
    logic        nf;
    logic        of;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  cond;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        flush;
    logic        res_valid;
    logic        taken;
    logic [31:0] redirect_pc;
    logic        illegal;
    logic [3:0]  flags;
    logic        pend_full;

    typedef struct {
        logic        tk;
        logic        il;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_flags;
    int         m_pend;
    int         n_chk;
    int         n_fail;

    cond_unit #(.ADDR_W(32), .MAX_PEND(3)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .flag_issue_i    (flag_issue),
        .flag_we_i       (flag_we),
        .zero_flag_i     (zf),
        .pos_flag_i      (pf),
        .neg_flag_i      (nf),
        .overflow_flag_i (of),
        .br_valid_i      (br_valid),
        .br_ready_o      (br_ready),
        .cond_i          (cond),
        .target_i        (target),
        .pc_next_i       (pc_next),
        .flush_i         (flush),
        .res_valid_o     (res_valid),
        .taken_o         (taken),
        .redirect_pc_o   (redirect_pc),
        .illegal_o       (illegal),
        .flags_o         (flags),
        .pend_full_o     (pend_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_eval(input logic [3:0] c,
                                            input logic [3:0] f);
        logic z, p, n, o;
        z = f[0]; p = f[1]; n = f[2]; o = f[3];
        case (c)
            4'd0:    return 2'b10;
            4'd1:    return 2'b00;
            4'd2:    return {z, 1'b0};
            4'd3:    return {~z, 1'b0};
            4'd4:    return {p, 1'b0};
            4'd5:    return {n, 1'b0};
            4'd6:    return {p & ~z, 1'b0};
            4'd7:    return {n | z, 1'b0};
            4'd8:    return {o, 1'b0};
            4'd9:    return {~o, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check, then advance the model.
    task automatic cyc(input logic fi, input logic fw, input logic [3:0] fl,
                       input logic bv, input logic [3:0] c,
                       input logic [31:0] tg, input logic [31:0] pn,
                       input logic fsh);
        exp_t       e;
        logic       rdy;
        logic [3:0] eff;
        logic [1:0] ev;
        @(negedge clk);
        flag_issue = fi;
        flag_we    = fw;
        {of, nf, pf, zf} = fl;
        br_valid   = bv;
        cond       = c;
        target     = tg;
        pc_next    = pn;
        flush      = fsh;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("res_valid", res_valid, !fsh);
            chk("illegal", illegal, fsh ? 1'b0 : e.il);
            chk("taken", taken, e.tk);
            chk("redirect_pc", redirect_pc, e.pc);
        end else begin
            chk("res_idle", res_valid, 1'b0);
            chk("illegal_idle", illegal, 1'b0);
        end
        rdy = (m_pend == 0) || (m_pend == 1 && fw);
        chk("br_ready", br_ready, rdy);
        chk("pend_full", pend_full, m_pend == 3);
        chk("flags", flags, m_flags);
        if (bv && rdy) begin
            eff  = fw ? fl : m_flags;
            ev   = ref_eval(c, eff);
            e.tk = ev[1];
            e.il = ev[0];
            e.pc = ev[1] ? tg : pn;
            exp_q.push_back(e);
        end
        if (fw) m_flags = fl;
        if (fi && !fw && m_pend < 3) m_pend++;
        else if (fw && !fi && m_pend > 0) m_pend--;
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic br(input logic [3:0] c, input logic [31:0] tg,
                      input logic [31:0] pn);
        cyc(0, 0, 4'h0, 1, c, tg, pn, 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_flags = 4'h0;
        m_pend = 0;
        rst_n = 1'b0;
        flag_issue = 0; flag_we = 0;
        {of, nf, pf, zf} = 4'h0;
        br_valid = 0; cond = 0; target = 0; pc_next = 0; flush = 0;
        #3;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_taken", taken, 1'b0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_pend_full", pend_full, 1'b0);
        chk("rst_ready", br_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // AL branch right after reset
        br(4'd0, 32'h100, 32'h4);
        idle();

        // Z and P set; EQ, NE, GT, GE back to back
        cyc(0, 1, 4'b0011, 0, 4'h0, 32'h0, 32'h0, 0);
        br(4'd2, 32'h40, 32'h8);
        br(4'd3, 32'h40, 32'h8);
        br(4'd6, 32'h40, 32'h8);
        br(4'd4, 32'h40, 32'h8);
        idle();

        // Stall behind an issued writer; accept on bypassed flags
        cyc(1, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        br(4'd2, 32'h80, 32'hc);
        br(4'd2, 32'h80, 32'hc);
        cyc(0, 1, 4'b0001, 1, 4'd2, 32'h80, 32'hc, 0);
        idle();

        // Saturation, drain, and simultaneous issue+write
        repeat (4) cyc(1, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        cyc(0, 1, 4'b1000, 1, 4'd0, 32'h11, 32'h22, 0);
        cyc(1, 1, 4'b0100, 1, 4'd0, 32'h11, 32'h22, 0);
        cyc(0, 1, 4'b0100, 1, 4'd0, 32'h11, 32'h22, 0);
        cyc(0, 1, 4'b0100, 1, 4'd5, 32'h33, 32'h44, 0);
        idle();

        // Flushed LT, then a reserved code
        br(4'd5, 32'h500, 32'h600);
        cyc(0, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 1);
        br(4'd12, 32'h200, 32'h300);
        idle();

        // Every code against a spread of flag patterns
        foreach (m_flags[i]) begin end
        for (int k = 0; k < 8; k++) begin
            logic [3:0] pats [8];
            pats = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                     4'b1000, 4'b0101, 4'b1010, 4'b1111};
            cyc(0, 1, pats[k], 0, 4'h0, 32'h0, 32'h0, 0);
            for (int c = 0; c < 16; c++)
                br(4'(c), $urandom, $urandom);
            idle();
        end

        // Asynchronous reset while stalled with pend = 2
        cyc(1, 0, 4'h0, 1, 4'd0, 32'h700, 32'h704, 0);
        cyc(1, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_taken", taken, 1'b0);
        chk("mid_rst_redirect", redirect_pc, 32'h0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_illegal", illegal, 1'b0);
        chk("mid_rst_flags", flags, 4'h0);
        chk("mid_rst_pend_full", pend_full, 1'b0);
        chk("mid_rst_ready", br_ready, 1'b1);
        m_flags = 4'h0;
        m_pend = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        br(4'd0, 32'h900, 32'h904);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
